// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and constants for the result arbiter and its users.
package cdb_arbiter_pkg;

   localparam int CDB_N_UNITS = 4;
   localparam int CDB_TAG_W   = 6;

   localparam int UNIT_INT = 0;
   localparam int UNIT_MUL = 1;
   localparam int UNIT_DIV = 2;
   localparam int UNIT_MEM = 3;

   typedef struct packed {
      logic [31:0]           cdb_data;
      logic [CDB_TAG_W-1:0]  cdb_tag;
      logic                  cdb_valid;
      logic                  cdb_branch;
      logic                  cdb_branch_taken;
   } cdb_bus;

   // Branch-only results carry no data but still need a broadcast slot.
   function automatic logic cdb_is_req(input cdb_bus b);
      return b.cdb_valid | b.cdb_branch;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result/broadcast bundle between execution units and the CDB arbiter.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int N_UNITS = CDB_N_UNITS
);

   cdb_bus [N_UNITS-1:0] unit_result;
   logic   [N_UNITS-1:0] unit_ready;
   cdb_bus               cdb_out;
   logic   [N_UNITS-1:0] cdb_grant;

   modport master (output unit_result, input unit_ready, input cdb_out, input cdb_grant);
   modport slave  (input unit_result, output unit_ready, output cdb_out, output cdb_grant);

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin arbiter: search begins one past i_ptr and wraps.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_gnt_idx,
   output logic             o_gnt_vld
);

   logic [IDX_W-1:0] w_idx;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_gnt_vld = 1'b0;
      w_idx     = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = IDX_W'((int'(i_ptr) + k) % N);
         if (!o_gnt_vld && i_req[w_idx]) begin
            o_gnt_vld    = 1'b1;
            o_gnt[w_idx] = 1'b1;
            o_gnt_idx    = w_idx;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-unit result holding slots, round-robin grant, registered broadcast.
// Optional same-cycle bypass of uncontended results when CDB_BYPASS_EN is defined.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_UNITS = CDB_N_UNITS,
   parameter int TAG_W   = CDB_TAG_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   cdb_arbiter_if.slave   bus
);

   localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

   if (TAG_W != CDB_TAG_W) begin : g_tag_w_check
      $error("cdb_arbiter: TAG_W must equal the cdb_bus tag width");
   end

   logic [N_UNITS-1:0] r_occ;
   logic [IDX_W-1:0]   r_ptr;
   cdb_bus             r_hold [N_UNITS];
   cdb_bus             r_cdb_out;
   logic [N_UNITS-1:0] r_cdb_grant;

   logic [N_UNITS-1:0] w_req;
   logic [N_UNITS-1:0] w_arb_req;
   logic [N_UNITS-1:0] w_gnt;
   logic [N_UNITS-1:0] w_ready;
   logic [N_UNITS-1:0] w_capture;
   logic [IDX_W-1:0]   w_gnt_idx;
   logic               w_gnt_vld;
   cdb_bus             w_sel;

   always_comb begin
      w_req = '0;
      for (int i = 0; i < N_UNITS; i++) begin
         w_req[i] = cdb_is_req(bus.unit_result[i]);
      end
   end

`ifdef CDB_BYPASS_EN
   // An empty slot competes with its incoming request at the same ring position.
   assign w_arb_req = r_occ | w_req;
`else
   assign w_arb_req = r_occ;
`endif

   rr_arbiter #(
      .N     (N_UNITS),
      .IDX_W (IDX_W)
   ) u_rr (
      .i_req     (w_arb_req),
      .i_ptr     (r_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_gnt_vld (w_gnt_vld)
   );

   // Fall-through: a slot that wins this cycle can accept a new result at the same edge.
   assign w_ready = ~r_occ | w_gnt;

`ifdef CDB_BYPASS_EN
   assign w_capture = w_req & w_ready & ~(w_gnt & ~r_occ);
`else
   assign w_capture = w_req & w_ready;
`endif

   always_comb begin
      w_sel = r_hold[w_gnt_idx];
`ifdef CDB_BYPASS_EN
      if (!r_occ[w_gnt_idx]) begin
         w_sel = bus.unit_result[w_gnt_idx];
      end
`endif
   end

   // Control state: occupancy, priority pointer and the broadcast register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_occ       <= '0;
         r_ptr       <= IDX_W'(N_UNITS - 1);
         r_cdb_out   <= '0;
         r_cdb_grant <= '0;
      end else if (flush) begin
         r_occ       <= '0;
         r_cdb_out   <= '0;
         r_cdb_grant <= '0;
      end else begin
         r_occ       <= (r_occ & ~w_gnt) | w_capture;
         r_cdb_out   <= w_gnt_vld ? w_sel : '0;
         r_cdb_grant <= w_gnt;
         if (w_gnt_vld) begin
            r_ptr <= w_gnt_idx;
         end
      end
   end

   // Holding data needs no reset; it is only observed while its occupied bit is set.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_UNITS; i++) begin
         if (w_capture[i]) begin
            r_hold[i] <= bus.unit_result[i];
         end
      end
   end

   assign bus.unit_ready = w_ready;
   assign bus.cdb_out    = r_cdb_out;
   assign bus.cdb_grant  = r_cdb_grant;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter; honours CDB_BYPASS_EN for latency expectations.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int NU = 4;
`ifdef CDB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic flush = 1'b0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   cdb_arbiter_if #(.N_UNITS(NU)) bus ();

   cdb_arbiter #(
      .N_UNITS (NU),
      .TAG_W   (CDB_TAG_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   int n_total = 0;
   int n_pass  = 0;

   cdb_bus                exp_q [NU][$];
   logic [CDB_TAG_W-1:0]  log_q [$];

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", name, obs, exp);
   endtask

   function automatic cdb_bus mk(input logic [5:0] tag, input logic [31:0] data,
                                 input bit v, input bit br, input bit tk);
      cdb_bus b;
      b.cdb_data = data;
      b.cdb_tag = tag;
      b.cdb_valid = v;
      b.cdb_branch = br;
      b.cdb_branch_taken = tk;
      return b;
   endfunction

   function automatic bit q_empty();
      for (int i = 0; i < NU; i++) if (exp_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      for (int i = 0; i < NU; i++) bus.unit_result[i] = '0;
   endtask

   task automatic present(input int u, input cdb_bus r);
      bus.unit_result[u] = r;
      exp_q[u].push_back(r);
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (!(q_empty() && bus.cdb_grant == '0) && k < 30) begin
         tick();
         k++;
      end
      check(name, 64'(q_empty() && bus.cdb_grant == '0), 64'd1);
   endtask

   // Monitor: every broadcast must match the head of its unit's expected queue.
   always @(negedge clk) begin
      int     g;
      cdb_bus e;
      logic [NU-1:0] w_req;
      if (mon_en && !rst) begin
         for (int i = 0; i < NU; i++)
            w_req[i] = bus.unit_result[i].cdb_valid | bus.unit_result[i].cdb_branch;
         check("protocol_req_while_not_ready", 64'(w_req & ~bus.unit_ready), 64'd0);
         if (bus.cdb_grant != '0) begin
            g = 0;
            for (int i = 0; i < NU; i++) if (bus.cdb_grant[i]) g = i;
            check("grant_onehot", 64'($onehot(bus.cdb_grant)), 64'd1);
            check("bcast_expected", 64'(exp_q[g].size() != 0), 64'd1);
            if (exp_q[g].size() != 0) begin
               e = exp_q[g].pop_front();
               check("bcast_content", 64'(bus.cdb_out), 64'(e));
            end
            log_q.push_back(bus.cdb_out.cdb_tag);
         end else begin
            check("idle_out_zero", 64'(bus.cdb_out), 64'd0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, sent, stall, cyc, pos, nmul;
      logic [CDB_TAG_W-1:0] exp_order [6];
      cdb_bus br;

      exp_order = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd9, 6'd10};
      clr();
      repeat (3) tick();
      rst = 1'b0;
      mon_en = 1'b1;
      tick();
      tick();

      // Reset / idle
      check("reset_cdb_out", 64'(bus.cdb_out), 64'd0);
      check("reset_grant", 64'(bus.cdb_grant), 64'd0);
      check("reset_ready", 64'(bus.unit_ready), 64'hF);

      // Single int result and its latency
      present(UNIT_INT, mk(6'h05, 32'h0000_00AA, 1'b1, 1'b0, 1'b0));
      tick();
      clr();
      lat = 1;
      while (bus.cdb_grant == '0 && lat < 10) begin
         tick();
         lat++;
      end
      check("single_latency", 64'(lat), 64'(LAT));
      check("single_grant", 64'(bus.cdb_grant), 64'b0001);
      check("single_tag", 64'(bus.cdb_out.cdb_tag), 64'h05);
      wait_drain("single_drain");

      // Mid-run reset, then all four units in one cycle
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rereset_ready", 64'(bus.unit_ready), 64'hF);
      log_q.delete();
      for (int i = 0; i < NU; i++) present(i, mk(6'(i + 1), 32'(100 + i), 1'b1, 1'b0, 1'b0));
      tick();
      clr();
      wait_drain("all4_drain");
      present(UNIT_INT, mk(6'd9, 32'h99, 1'b1, 1'b0, 1'b0));
      present(UNIT_MUL, mk(6'd10, 32'h1010, 1'b1, 1'b0, 1'b0));
      tick();
      clr();
      wait_drain("round2_drain");
      check("rr_count", 64'(log_q.size()), 64'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < log_q.size()) check("rr_order", 64'(log_q[k]), 64'(exp_order[k]));
      end

      // Mul streams while int requests once
      log_q.delete();
      sent = 0;
      stall = 0;
      cyc = 0;
      present(UNIT_INT, mk(6'd40, 32'h4040, 1'b1, 1'b0, 1'b0));
      while (sent < 12 && cyc < 40) begin
         if (cyc == 1) bus.unit_result[UNIT_INT] = '0;
         #1;
         if (bus.unit_ready[UNIT_MUL]) begin
            present(UNIT_MUL, mk(6'(16 + sent), 32'(32'h1000 + sent), 1'b1, 1'b0, 1'b0));
            sent++;
         end else begin
            bus.unit_result[UNIT_MUL] = '0;
            stall++;
         end
         tick();
         cyc++;
      end
      clr();
      wait_drain("stream_drain");
      check("stream_sent", 64'(sent), 64'd12);
      check("stream_mul_stall_le1", 64'(stall <= 1), 64'd1);
      pos = 99;
      nmul = 0;
      for (int k = 0; k < log_q.size(); k++) begin
         if (log_q[k] == 6'd40 && pos == 99) pos = k;
         if (log_q[k] >= 6'd16 && log_q[k] < 6'd28) nmul++;
      end
      check("int_fairness", 64'(pos < NU), 64'd1);
      check("stream_mul_count", 64'(nmul), 64'd12);

      // Branch-only result from int
      br = mk(6'd7, 32'h0, 1'b0, 1'b1, 1'b1);
      present(UNIT_INT, br);
      tick();
      clr();
      lat = 1;
      while (bus.cdb_grant == '0 && lat < 10) begin
         tick();
         lat++;
      end
      check("branch_latency", 64'(lat), 64'(LAT));
      check("branch_grant", 64'(bus.cdb_grant), 64'b0001);
      check("branch_flags", 64'({bus.cdb_out.cdb_valid, bus.cdb_out.cdb_branch,
                                  bus.cdb_out.cdb_branch_taken}), 64'b011);
      wait_drain("branch_drain");

      // Three slots loaded, then flush
      bus.unit_result[UNIT_INT] = mk(6'h31, 32'h31, 1'b1, 1'b0, 1'b0);
`ifdef CDB_BYPASS_EN
      present(UNIT_MUL, mk(6'h32, 32'h32, 1'b1, 1'b0, 1'b0));
`else
      bus.unit_result[UNIT_MUL] = mk(6'h32, 32'h32, 1'b1, 1'b0, 1'b0);
`endif
      bus.unit_result[UNIT_DIV] = mk(6'h33, 32'h33, 1'b1, 1'b0, 1'b0);
      tick();
      clr();
`ifdef CDB_BYPASS_EN
      check("preflush_ready", 64'(bus.unit_ready), 64'b1110);
`else
      check("preflush_ready", 64'(bus.unit_ready), 64'b1010);
`endif
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_cdb_out", 64'(bus.cdb_out), 64'd0);
      check("flush_grant", 64'(bus.cdb_grant), 64'd0);
      check("flush_ready", 64'(bus.unit_ready), 64'hF);
      repeat (8) tick();
      wait_drain("flush_drain");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
